// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 3-stage core: resolves load-use, redirect and
// multi-cycle memory hazards and counts stall/flush cycles for CSR readout.
module pipe_hazard_ctrl #(
    parameter logic [1:0]  WB_MEM       = 2'd0,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             rs1_used_d,
    input  logic             rs2_used_d,
    input  logic [4:0]       rd_x,
    input  logic             reg_we_x,
    input  logic [1:0]       wb_sel_x,
    input  logic             redirect_x,
    input  logic             mem_req_x,
    input  logic             mem_ready,
    output logic             stall_f,
    output logic             stall_fd,
    output logic             stall_x,
    output logic             bubble_x,
    output logic             flush_fd,
    output logic             flush_x,
    output logic             mem_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned REM_W = 4;
    localparam int unsigned TMO_W = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [REM_W-1:0]   flush_rem, flush_rem_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic               load_use;
    logic               mem_wait;

    assign load_use = reg_we_x && (wb_sel_x == WB_MEM) && (rd_x != 5'd0) &&
                      ((rs1_used_d && (rs1_d == rd_x)) || (rs2_used_d && (rs2_d == rd_x)));
    assign mem_wait = mem_req_x && !mem_ready;
    assign state_o  = 2'(state);

    // Next state and zero-latency pipeline controls
    always_comb begin
        state_nxt     = state;
        flush_rem_nxt = flush_rem;
        tmo_cnt_nxt   = tmo_cnt;
        stall_f       = 1'b0;
        stall_fd      = 1'b0;
        stall_x       = 1'b0;
        bubble_x      = 1'b0;
        flush_fd      = 1'b0;
        flush_x       = 1'b0;
        mem_err       = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_wait) begin
                    stall_f     = 1'b1;
                    stall_fd    = 1'b1;
                    stall_x     = 1'b1;
                    state_nxt   = ST_MEM_WAIT;
                    tmo_cnt_nxt = TMO_W'(1);
                end else if (redirect_x) begin
                    flush_fd = 1'b1;
                    flush_x  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt     = ST_FLUSH;
                        flush_rem_nxt = REM_W'(FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    stall_f  = 1'b1;
                    stall_fd = 1'b1;
                    bubble_x = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                stall_f  = 1'b1;
                stall_fd = 1'b1;
                if (mem_ready) begin
                    stall_x   = 1'b1;
                    state_nxt = ST_RUN;
                end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT)) begin
                    // Abort squashes the stuck X instruction instead of holding it
                    mem_err   = 1'b1;
                    flush_x   = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    stall_x     = 1'b1;
                    tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            ST_FLUSH: begin
                flush_fd = 1'b1;
                flush_x  = 1'b1;
                if (redirect_x) begin
                    flush_rem_nxt = REM_W'(FLUSH_CYCLES - 1);
                end else if (flush_rem <= REM_W'(1)) begin
                    flush_rem_nxt = '0;
                    state_nxt     = ST_RUN;
                end else begin
                    flush_rem_nxt = flush_rem - REM_W'(1);
                end
            end
            default: state_nxt = ST_RUN;
        endcase
        if (rst) begin
            stall_f  = 1'b0;
            stall_fd = 1'b0;
            stall_x  = 1'b0;
            bubble_x = 1'b0;
            flush_fd = 1'b0;
            flush_x  = 1'b0;
            mem_err  = 1'b0;
        end
    end

    // State and free-running performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_rem <= '0;
            tmo_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_rem <= flush_rem_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            stall_cnt <= stall_cnt + CNT_W'(stall_f);
            flush_cnt <= flush_cnt + CNT_W'(flush_fd);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 3-stage RISC-V core (F/D, X, M/WB). Watches X-stage control (rd_x, reg_we_x, wb_sel_x, redirect, memory request) against D-stage source registers. Generates per-stage stall and flush/bubble controls so the X->M control pipe only ever captures valid instructions or bubbles. Also keeps free-running stall and flush cycle counters for CSR readout.

Parameters:
WB_MEM, 2'd0, wb_sel encoding meaning "writeback from memory load"
FLUSH_CYCLES, 2, cycles flush_fd/flush_x held after a redirect (1..15)
MEM_TIMEOUT, 255, max cycles waiting on mem_ready before error abort (1..65535)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
rs1_d  in  5  D-stage source register 1
rs2_d  in  5  D-stage source register 2
rs1_used_d  in  1  D-stage instruction reads rs1
rs2_used_d  in  1  D-stage instruction reads rs2
rd_x  in  5  X-stage destination register
reg_we_x  in  1  X-stage writes register file
wb_sel_x  in  2  X-stage writeback select
redirect_x  in  1  X-stage taken branch/jal/jalr (PC redirect)
mem_req_x  in  1  X-stage issues load/store to multi-cycle memory/MMIO
mem_ready  in  1  memory completes request this cycle
stall_f  out  1  hold PC
stall_fd  out  1  hold F->D register
stall_x  out  1  hold D->X register
bubble_x  out  1  insert NOP into D->X register (zero reg_we/mem controls)
flush_fd  out  1  squash F->D register
flush_x  out  1  squash D->X register (X->M pipe receives reg_we=0)
mem_err  out  1  one-cycle pulse on memory timeout
state_o  out  2  FSM state (0 RUN, 1 FLUSH, 2 MEM_WAIT)
stall_cnt  out  CNT_W  cycles with stall_f=1
flush_cnt  out  CNT_W  cycles with flush_fd=1

Behaviour:
- Reset (async, any time incl. mid-FLUSH/MEM_WAIT): state=RUN, flush counter=0, timeout counter=0, stall_cnt=flush_cnt=0; all control outputs 0 while rst high.
- load_use = reg_we_x & (wb_sel_x==WB_MEM) & (rd_x!=0) & ((rs1_used_d & rs1_d==rd_x) | (rs2_used_d & rs2_d==rd_x)).
- mem_wait = mem_req_x & ~mem_ready.
- RUN, priority mem_wait > redirect_x > load_use:
  - mem_wait: stall_f=stall_fd=stall_x=1 same cycle (combinational); next state MEM_WAIT, timeout cnt=1.
  - redirect_x: flush_fd=flush_x=1 same cycle; if FLUSH_CYCLES>1 next state FLUSH with remaining=FLUSH_CYCLES-1, else stay RUN.
  - load_use: stall_f=stall_fd=1, bubble_x=1 for exactly this cycle; stays RUN (bubble clears hazard next cycle).
  - none: all controls 0.
- MEM_WAIT: stall_f=stall_fd=stall_x=1 every cycle. mem_ready=1 -> stalls still 1 this cycle, next RUN. Else timeout cnt==MEM_TIMEOUT -> mem_err=1, flush_x=1 this cycle, next RUN. Else timeout cnt+1. redirect_x/load_use ignored here (instruction held in X; re-evaluated in RUN).
- FLUSH: flush_fd=flush_x=1; remaining-1; remaining==1 -> next RUN. New redirect_x during FLUSH reloads remaining=FLUSH_CYCLES-1. mem_req_x ignored (X holds flushed bubble).
- Asserted stall and flush for the same stage never coexist; flush wins only via FSM priority above.
- Counters: stall_cnt +1 per cycle with stall_f=1, flush_cnt +1 per cycle with flush_fd=1; wrap modulo 2^CNT_W, no saturation.
- Only state, counters registered; all stall/flush/bubble outputs combinational from state and inputs (zero-latency).

Test Plan:
- Load-use: reg_we_x=1, wb_sel_x=0, rd_x=5, rs1_d=5, rs1_used_d=1 for 1 cycle -> stall_f=stall_fd=bubble_x=1 that cycle only; rd_x=0 variant -> no stall; stall_cnt=1.
- Redirect: redirect_x pulse 1 cycle, FLUSH_CYCLES=2 -> flush_fd=flush_x=1 for exactly 2 cycles, state_o 0->1->0, flush_cnt=2; second redirect in cycle 2 -> 3 flush cycles total.
- Simultaneous: mem_req_x=1, mem_ready=0, redirect_x=1, load_use=1 -> only stalls asserted, state MEM_WAIT; mem_ready after 4 cycles -> RUN, stall_cnt=5.
- Timeout: MEM_TIMEOUT=3, mem_ready held 0 -> mem_err single pulse with flush_x=1 on 4th stall cycle, next state RUN.
- Async reset asserted mid-FLUSH and mid-MEM_WAIT (between clock edges) -> outputs 0 immediately, state_o=0, counters 0; after release, normal RUN operation.
- Counter wrap: CNT_W=4, 17 stall cycles -> stall_cnt=1.
